pwm_gen: RTL and testbench

- Multi-channel PWM output stage. Sits directly downstream of the fade/cycle generators.
- Consumes one duty value per channel, e.g. the R/G/B fade levels, and drives the LED pins.
- Duty updates are double-buffered and committed only at a period boundary, so outputs never glitch mid-period.
- Provides a period-start strobe that upstream stages can use as a timebase.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_channel.sv | 36 +++
 rtl/pwm_gen.sv | 71 +++++++
 tb/tb_pwm_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM output stage.
package pwm_pkg;

  localparam int unsigned PWM_INTERVAL_DEFAULT = 1200;
  localparam int unsigned NUM_CH_DEFAULT       = 3;
  // Common-anode LEDs: a pin driven low lights the segment.
  localparam bit          ACTIVE_LOW_DEFAULT   = 1'b1;

  // Duty values at or above the period saturate to the period length.
  function automatic logic [31:0] duty_clamp(input logic [31:0] duty,
                                             input logic [31:0] interval);
    return (duty > interval) ? interval : duty;
  endfunction

  // Pin level for a logical on/off under the selected polarity.
  function automatic logic pin_level(input logic on, input bit active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (shadow/active), compare and pin flop.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
  parameter int unsigned DUTY_W       = $clog2(PWM_INTERVAL + 1),
  parameter bit          ACTIVE_LOW   = ACTIVE_LOW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              commit,
  input  logic              bypass,
  input  logic [DUTY_W-1:0] duty,
  input  logic [DUTY_W-1:0] pcnt,
  output logic              pwm
);

  logic [DUTY_W-1:0] shadow;
  logic [DUTY_W-1:0] active;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      pwm    <= pin_level(1'b0, ACTIVE_LOW);
    end else begin
      if (load) shadow <= duty;
      // A strobe landing on the wrap cycle goes straight to active.
      if (bypass)      active <= DUTY_W'(duty_clamp(32'(duty), 32'(PWM_INTERVAL)));
      else if (commit) active <= DUTY_W'(duty_clamp(32'(shadow), 32'(PWM_INTERVAL)));
      pwm <= pin_level(pcnt < active, ACTIVE_LOW);
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// Multi-channel PWM generator with period-boundary duty commit.
// Optional PWM_GEN_PHASE_STAGGER_EN spreads channel rising edges across the period.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
  parameter int unsigned NUM_CH       = NUM_CH_DEFAULT,
  parameter int unsigned DUTY_W       = $clog2(PWM_INTERVAL + 1),
  parameter bit          ACTIVE_LOW   = ACTIVE_LOW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DUTY_W-1:0] duty_in,
  input  logic                     duty_valid,
  output logic                     update_ack,
  output logic                     period_start,
  output logic [NUM_CH-1:0]        pwm_out
);

  logic [DUTY_W-1:0] cnt;
  logic              pending;
  logic              wrap;

  assign wrap = (cnt == DUTY_W'(PWM_INTERVAL - 1));

  // Period counter, pending-commit flag and period-aligned strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      pending      <= 1'b0;
      update_ack   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= wrap ? '0 : cnt + DUTY_W'(1);
      pending      <= wrap ? 1'b0 : (pending | duty_valid);
      update_ack   <= wrap & (pending | duty_valid);
      period_start <= (cnt == '0);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DUTY_W-1:0] pcnt;
`ifdef PWM_GEN_PHASE_STAGGER_EN
    localparam int unsigned SW  = DUTY_W + 1;
    localparam int unsigned OFS = g * (PWM_INTERVAL / NUM_CH);
    logic [SW-1:0] sum;
    // Offset is below one period, so a single conditional subtract wraps it.
    assign sum  = {1'b0, cnt} + SW'(OFS);
    assign pcnt = (sum >= SW'(PWM_INTERVAL)) ? DUTY_W'(sum - SW'(PWM_INTERVAL))
                                             : DUTY_W'(sum);
`else
    assign pcnt = cnt;
`endif

    pwm_channel #(
      .PWM_INTERVAL (PWM_INTERVAL),
      .DUTY_W       (DUTY_W),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .load   (duty_valid),
      .commit (wrap & pending),
      .bypass (wrap & duty_valid),
      .duty   (duty_in[g*DUTY_W +: DUTY_W]),
      .pcnt   (pcnt),
      .pwm    (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen (PWM_INTERVAL=12, NUM_CH=3, active-high).
module tb_pwm_gen;

  localparam int N  = 12;
  localparam int NC = 3;
  localparam int DW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              duty_valid = 1'b0;
  logic [NC*DW-1:0]  duty_in = '0;
  logic              update_ack;
  logic              period_start;
  logic [NC-1:0]     pwm_out;

  pwm_gen #(
    .PWM_INTERVAL (N),
    .NUM_CH       (NC),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .update_ack   (update_ack),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pwm;
    int ack;
    int ps;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_cnt    = 0;
  int   m_pend   = 0;
  int   m_shadow [NC];
  int   m_active [NC];
  int   obs_pwm  = 0;
  int   obs_ack  = 0;
  int   obs_ps   = 0;
  int   ack_cnt  = 0;
  int   rise_at  [NC];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ofs(input int i);
`ifdef PWM_GEN_PHASE_STAGGER_EN
    return i * (N / NC);
`else
    return 0 * i;
`endif
  endfunction

  function automatic logic [NC*DW-1:0] pack(input int a0, input int a1, input int a2);
    return {DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  // Model one clock of behaviour, queue the expectation, then compare after the edge.
  task automatic tick();
    exp_t e;
    bit   wrap;
    bit   upd;
    e = '{0, 0, 0};
    if (rst) begin
      m_cnt  = 0;
      m_pend = 0;
      for (int i = 0; i < NC; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      wrap = (m_cnt == N - 1);
      upd  = wrap && (m_pend != 0 || duty_valid);
      for (int i = 0; i < NC; i++)
        if (((m_cnt + ofs(i)) % N) < m_active[i]) e.pwm |= (1 << i);
      e.ps  = (m_cnt == 0) ? 1 : 0;
      e.ack = upd ? 1 : 0;
      if (duty_valid)
        for (int i = 0; i < NC; i++) m_shadow[i] = int'(duty_in[i*DW +: DW]);
      if (upd) m_active = m_shadow;
      m_pend = (!wrap && (m_pend != 0 || duty_valid)) ? 1 : 0;
      m_cnt  = wrap ? 0 : m_cnt + 1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    obs_pwm = int'(pwm_out);
    obs_ack = int'(update_ack);
    obs_ps  = int'(period_start);
    check("pwm_out", obs_pwm, e.pwm);
    check("update_ack", obs_ack, e.ack);
    check("period_start", obs_ps, e.ps);
    ack_cnt += obs_ack;
  endtask

  task automatic load(input int a0, input int a1, input int a2);
    duty_in    = pack(a0, a1, a2);
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int g = 0;
    while (m_cnt != v && g < 2 * N) begin
      tick();
      g++;
    end
    if (m_cnt != v) check("wait_cnt", m_cnt, v);
  endtask

  // Run to the next period start, then count high cycles per channel over one period.
  task automatic measure(input string tag, input int e0, input int e1, input int e2,
                         input int eack);
    int g = 0;
    int hi [NC];
    int b;
    do begin
      tick();
      g++;
    end while (obs_ps == 0 && g < 2 * N);
    check({tag, "_period_start_seen"}, obs_ps, 1);
    check({tag, "_ack_count"}, ack_cnt, eack);
    for (int i = 0; i < NC; i++) begin
      hi[i]      = 0;
      rise_at[i] = -1;
    end
    for (int j = 0; j < N; j++) begin
      if (j > 0) tick();
      for (int i = 0; i < NC; i++) begin
        b = (obs_pwm >> i) & 1;
        hi[i] += b;
        if (b == 1 && rise_at[i] < 0) rise_at[i] = j;
      end
    end
    check({tag, "_ch0_high"}, hi[0], e0);
    check({tag, "_ch1_high"}, hi[1], e1);
    check({tag, "_ch2_high"}, hi[2], e2);
  endtask

  initial begin
    int total;

    // Reset held with a live strobe: nothing may be captured.
    rst        = 1'b1;
    duty_valid = 1'b1;
    duty_in    = pack(12, 6, 0);
    repeat (3) tick();
    duty_valid = 1'b0;
    rst        = 1'b0;
    tick();
    check("first_period_start", obs_ps, 1);
    check("post_reset_pwm", obs_pwm, 0);

    // Basic duty, loaded mid-period.
    wait_cnt(4);
    ack_cnt = 0;
    load(3, 6, 9);
    measure("basic", 3, 6, 9, 1);
    check("basic_rise_ch0", rise_at[0], 0);
    check("basic_rise_ch2", rise_at[2], 0);

    // Latest strobe before the wrap wins.
    wait_cnt(3);
    ack_cnt = 0;
    load(2, 2, 2);
    wait_cnt(8);
    load(5, 5, 5);
    measure("latest", 5, 5, 5, 1);

    // Strobe on the wrap cycle commits for the very next period.
    wait_cnt(11);
    ack_cnt = 0;
    load(7, 1, 10);
    check("bypass_ack", obs_ack, 1);
    measure("bypass", 7, 1, 10, 1);

    // Boundaries: zero, full and saturated duty over three periods.
    wait_cnt(5);
    ack_cnt = 0;
    load(0, 12, 15);
    measure("bound0", 0, 12, 12, 1);
    ack_cnt = 0;
    measure("bound1", 0, 12, 12, 0);
    measure("bound2", 0, 12, 12, 0);

    // Equal duty: rising-edge placement depends on phase staggering.
    wait_cnt(2);
    ack_cnt = 0;
    load(4, 4, 4);
    measure("stagger", 4, 4, 4, 1);
`ifdef PWM_GEN_PHASE_STAGGER_EN
    check("stagger_rise_ch0", rise_at[0], 0);
    check("stagger_rise_ch1", rise_at[1], 8);
    check("stagger_rise_ch2", rise_at[2], 4);
`else
    check("stagger_rise_ch0", rise_at[0], 0);
    check("stagger_rise_ch1", rise_at[1], 0);
    check("stagger_rise_ch2", rise_at[2], 0);
`endif

    // Reset mid-period clears active duty until a new load commits.
    ack_cnt = 0;
    load(6, 6, 6);
    measure("pre_rst", 6, 6, 6, 1);
    wait_cnt(7);
    rst = 1'b1;
    tick();
    check("rst_mid_pwm", obs_pwm, 0);
    rst = 1'b0;
    total   = 0;
    ack_cnt = 0;
    for (int j = 0; j < 2 * N; j++) begin
      tick();
      total += obs_pwm;
    end
    check("post_rst_idle_high", total, 0);
    check("post_rst_idle_ack", ack_cnt, 0);
    load(2, 4, 8);
    measure("post_rst", 2, 4, 8, 1);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
